pc_fetch_unit: RTL
==================

Name: pc_fetch_unit

Overview:
- Owns the program counter. It consumes the PCSrc decision and branch/jump operands from the execute side, and issues instruction fetches to instruction memory over a req/ack handshake.
- It computes the next PC (sequential, PC-relative, or jalr register-relative) and traps misaligned targets to a fixed vector.
- It counts retired instructions.
- It sits between instruction memory and the decode/execute datapath, at the consuming end of the PC-select interface.

Parameters:
- RESET_PC, 32'h0040_0000, PC value loaded on reset.
- TRAP_VECTOR, 32'h0040_0100, PC loaded when a misaligned target is detected.

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- IMem_Req  out  1  fetch request, held until acknowledged.
- IMem_Addr  out  32  fetch address; always equals PC while IMem_Req=1.
- IMem_Ack  in  1  memory accepted the request; IMem_RData is valid in the same cycle.
- IMem_RData  in  32  fetched instruction word.
- Instr_Valid  out  1  Instr/PC/PC_Plus_4 hold a fetched instruction awaiting execution.
- Instr  out  32  latched instruction word.
- PC  out  32  address of the current instruction.
- PC_Plus_4  out  32  PC+4, used as the link value for jal/jalr.
- Exec_Done  in  1  execute finished the current instruction; PCSrc/ExtImm/RD1 are valid this cycle.
- PCSrc  in  2  next-PC select: 00 = PC+4, 01 = PC+ExtImm (taken branch/jal), 10 = (RD1+ExtImm)&~1 (jalr), 11 = reserved, treated as 00.
- ExtImm  in  32  sign-extended immediate offset.
- RD1  in  32  jalr base register value.
- Trap  out  1  one-cycle pulse when a misaligned target is redirected to TRAP_VECTOR.
- Trap_Addr  out  32  offending target, held until the next trap or reset.
- Instret  out  32  retired instruction count.

Behaviour:
- Reset (async, any state, including mid-fetch):
  - state=FETCH, PC=RESET_PC, Instr=0, Trap_Addr=0, Instret=0.
  - Trap=0, Instr_Valid=0.
  - IMem_Req=1 in the first cycle after RESET deasserts.
- States: FETCH, ISSUE, TRAP.
- FETCH:
  - IMem_Req=1, IMem_Addr=PC, Instr_Valid=0.
  - On IMem_Ack: Instr<=IMem_RData, go ISSUE.
  - Without IMem_Ack: hold PC and keep the request asserted, for unbounded wait.
- ISSUE:
  - Instr_Valid=1, IMem_Req=0.
  - Wait for Exec_Done. Exec_Done is ignored in FETCH and TRAP.
  - On Exec_Done, compute target T:
    - 00/11: PC+4.
    - 01: PC+ExtImm.
    - 10: (RD1+ExtImm)&32'hFFFF_FFFE.
  - All arithmetic is 32-bit modulo 2^32; wrap-around is silent.
  - Instret<=Instret+1 on every Exec_Done in ISSUE, wrapping from FFFF_FFFF to 0.
  - If T[1:0]==00: PC<=T, go FETCH.
  - Otherwise: Trap_Addr<=T, PC<=TRAP_VECTOR, go TRAP.
- TRAP:
  - Trap=1 for exactly this one cycle, Instr_Valid=0, IMem_Req=0.
  - Next cycle go FETCH.
  - The trapping instruction still counts as retired.
- Latency: with IMem_Ack in the first FETCH cycle, Instr_Valid rises 1 cycle after the fetch request. Exec_Done to the next IMem_Req is 1 cycle; 2 cycles on a trap.
- PC_Plus_4 is combinational from PC.
- Instr, PC and PC_Plus_4 are stable for the whole ISSUE state.
- IMem_Ack while IMem_Req=0 is ignored.
- Simultaneous RESET and any event: reset wins.
- No outputs are X after reset.

Test Plan:
- Reset mid-fetch: assert RESET while in FETCH with Ack pending -> PC=0x00400000, Instret=0, Trap=0; IMem_Req=1 with IMem_Addr=0x00400000 the cycle after release.
- Sequential flow: PC=0x00400000, Ack same cycle with RData=0x00000013, then Exec_Done with PCSrc=00 -> Instr=0x00000013, next IMem_Addr=0x00400004, Instret=1.
- Branch and wait states: PC=0x00400010, PCSrc=01, ExtImm=0xFFFFFFF8 -> next PC=0x00400008. Withhold Ack for 3 cycles -> IMem_Req stays 1, address stays stable, Instr_Valid=0.
- jalr LSB clear: PCSrc=10, RD1=0x00400021, ExtImm=3 -> (0x00400024)&~1 = 0x00400024 -> PC=0x00400024, no trap.
- Misaligned trap: PCSrc=01, PC=0x00400000, ExtImm=6 -> Trap pulses for 1 cycle, Trap_Addr=0x00400006, then IMem_Addr=0x00400100, Instret incremented.
- Wrap: preload Instret=0xFFFFFFFF and PC=0xFFFFFFFC with PCSrc=00 -> Instret=0, PC=0x00000000.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: owns the program counter, fetches instructions over a
// req/ack handshake, selects the next PC from the execute-side PCSrc
// decision, redirects misaligned targets to a trap vector and counts
// retired instructions.
module pc_fetch_unit #(
   parameter logic [31:0] RESET_PC    = 32'h0040_0000,
   parameter logic [31:0] TRAP_VECTOR = 32'h0040_0100
) (
   input  logic        CLK,
   input  logic        RESET,
   output logic        IMem_Req,
   output logic [31:0] IMem_Addr,
   input  logic        IMem_Ack,
   input  logic [31:0] IMem_RData,
   output logic        Instr_Valid,
   output logic [31:0] Instr,
   output logic [31:0] PC,
   output logic [31:0] PC_Plus_4,
   input  logic        Exec_Done,
   input  logic [1:0]  PCSrc,
   input  logic [31:0] ExtImm,
   input  logic [31:0] RD1,
   output logic        Trap,
   output logic [31:0] Trap_Addr,
   output logic [31:0] Instret
);

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      ISSUE = 2'd1,
      TRAP  = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] trap_addr_q, trap_addr_d;
   logic [31:0] instret_q, instret_d;
   logic        req_q, req_d;
   logic        valid_q, valid_d;
   logic        trap_q, trap_d;

   logic [31:0] pc_plus_4;
   logic [31:0] target;

   assign pc_plus_4 = pc_q + 32'd4;

   // Next-PC candidate selected by PCSrc; the reserved code falls back to PC+4.
   always_comb begin
      target = pc_plus_4;
      case (PCSrc)
         2'b01:   target = pc_q + ExtImm;
         2'b10:   target = (RD1 + ExtImm) & 32'hFFFF_FFFE;
         default: target = pc_plus_4;
      endcase
   end

   // Next-state, datapath updates and registered output flags.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      instr_d     = instr_q;
      trap_addr_d = trap_addr_q;
      instret_d   = instret_q;
      case (state_q)
         FETCH: begin
            if (IMem_Ack) begin
               instr_d = IMem_RData;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (Exec_Done) begin
               instret_d = instret_q + 32'd1;
               if (target[1:0] == 2'b00) begin
                  pc_d    = target;
                  state_d = FETCH;
               end else begin
                  trap_addr_d = target;
                  pc_d        = TRAP_VECTOR;
                  state_d     = TRAP;
               end
            end
         end
         TRAP:    state_d = FETCH;
         default: state_d = FETCH;
      endcase
      // Output flags are decoded from the next state so they line up with it.
      req_d   = (state_d == FETCH);
      valid_d = (state_d == ISSUE);
      trap_d  = (state_d == TRAP);
   end

   // State registers with asynchronous reset.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q     <= FETCH;
         pc_q        <= RESET_PC;
         instr_q     <= '0;
         trap_addr_q <= '0;
         instret_q   <= '0;
         req_q       <= 1'b1;
         valid_q     <= 1'b0;
         trap_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         instr_q     <= instr_d;
         trap_addr_q <= trap_addr_d;
         instret_q   <= instret_d;
         req_q       <= req_d;
         valid_q     <= valid_d;
         trap_q      <= trap_d;
      end
   end

   assign IMem_Req    = req_q;
   assign IMem_Addr   = pc_q;
   assign Instr_Valid = valid_q;
   assign Instr       = instr_q;
   assign PC          = pc_q;
   assign PC_Plus_4   = pc_plus_4;
   assign Trap        = trap_q;
   assign Trap_Addr   = trap_addr_q;
   assign Instret     = instret_q;

endmodule
